spi_slave_reg_ctrl: RTL and testbench
=====================================

# spi_slave_reg_ctrl

Register-access protocol controller that sits behind `spi_slave` on the system clock side. It consumes received words and frame-end events, and decodes each SPI frame as command, address, then data bytes with address auto-increment. It drives a simple request/acknowledge register bus and feeds read data back to `spi_slave` for transmission. It owns both `spi_slave` handshakes (`rdy_ack_i`, `last_byte_ack_i`), so no other logic touches them.

## Interface
- `ADDR_WIDTH`, 8: register address width, 1..8; taken from the low bits of the address byte.
- `TIMEOUT_CYCLES`, 16: register-bus watchdog limit; used only with `SPI_REG_CTRL_TIMEOUT_EN`.

Ports:
- `clk_i` in 1: system clock, same clock as `spi_slave` `clk_i`.
- `rst_i` in 1: reset, synchronous, active-high.
- `en_i` in 1: enable; low acts as a synchronous reset of the block.
- `spi_rdy_i` in 1: word-ready level, from `spi_slave` `rdy_o`.
- `spi_data_i` in 8: received word, from `bus_o`.
- `spi_first_byte_i` in 1: first word of frame, from `first_byte_o`.
- `spi_last_byte_i` in 1: frame-end level, from `last_byte_o`.
- `spi_rdy_ack_o` out 1: one-cycle ack pulse, to `rdy_ack_i`.
- `spi_last_byte_ack_o` out 1: one-cycle ack pulse, to `last_byte_ack_i`.
- `spi_tx_data_o` out 8: next word to transmit, to `bus_i`.
- `reg_addr_o` out ADDR_WIDTH: register address.
- `reg_data_o` out 8: write data.
- `reg_wr_o` out 1: write request; held until `reg_ack_i`.
- `reg_rd_o` out 1: read request; held until `reg_ack_i`.
- `reg_data_i` in 8: read data; valid in the cycle `reg_ack_i` is high.
- `reg_ack_i` in 1: access complete.
- `err_o` out 1: sticky watchdog error.

## Operation
- All outputs are registered. Reset (`rst_i` or `!en_i`) value of every output is 0, `spi_tx_data_o` = 0x00. State resets to S_CMD.
- Frame format:
  - Byte 0 is the command; `cmd[7]` = 1 means read, 0 means write, and `cmd[6:0]` is ignored.
  - Byte 1 is the address.
  - Bytes 2.. are data.
- States: S_CMD, S_ADDR, S_DATA (waiting states); S_WR, S_RD (bus access); S_ACK, S_LAST, S_HOLD.
- Waiting-state rules:
  - `spi_rdy_i` high with `spi_first_byte_i` high is always decoded as a command: latch the rd flag and clear `err_o`. Go to S_ACK with next phase S_ADDR.
  - S_ADDR with `spi_rdy_i`: latch `reg_addr_o` = `spi_data_i[ADDR_WIDTH-1:0]`.
    - Read: go to S_RD.
    - Write: go to S_ACK, next phase S_DATA.
  - S_DATA with `spi_rdy_i`:
    - Write: latch `reg_data_o` = `spi_data_i` and go to S_WR.
    - Read: the received byte is a dummy and is dropped; go to S_RD to prefetch.
  - `spi_rdy_i` has priority over `spi_last_byte_i` when both are high. In that case the byte is processed and the frame end is handled on the next return to a waiting state.
  - `spi_last_byte_i` high (and `spi_rdy_i` low): go to S_LAST.
- S_WR: hold `reg_wr_o` until `reg_ack_i`. On ack, increment the address, then go to S_ACK with next phase S_DATA.
- S_RD: hold `reg_rd_o` until `reg_ack_i`. On ack, load `spi_tx_data_o` = `reg_data_i`, increment the address, then go to S_ACK with next phase S_DATA.
- S_ACK: pulse `spi_rdy_ack_o` for one cycle, then go to S_HOLD.
- S_LAST: pulse `spi_last_byte_ack_o` for one cycle and set `spi_tx_data_o` = 0x00. Go to S_HOLD with next phase S_CMD.
- S_HOLD: one cycle with `spi_rdy_i`/`spi_last_byte_i` ignored, covering the registered `rdy_o` clear latency. Then go to the latched next phase.
- Address increments modulo 2^ADDR_WIDTH (0xFF -> 0x00 with ADDR_WIDTH = 8).
- `reg_wr_o` and `reg_rd_o` are never high together. `reg_ack_i` outside S_WR/S_RD is ignored.
- A frame end during S_WR/S_RD does not abort the access. The access completes and the frame end is then processed.

## Timing
- `spi_rdy_i` sampled high in cycle N of a waiting state: `reg_wr_o`/`reg_rd_o` high at N+1.
- Same-cycle `reg_ack_i` at N+1: the request drops and `spi_rdy_ack_o` pulses at N+2.
- Bytes that need no access (command, write address): `spi_rdy_ack_o` pulses at N+1 and the controller is back in a waiting state at N+3.
- `spi_tx_data_o` updates in the cycle after `reg_ack_i`. The SPI master must leave at least (access latency + 4) `clk_i` cycles of byte gap for read data to be valid.
- Minimum byte period with zero-wait register bus: 4 `clk_i` cycles.

## Configuration
- `SPI_REG_CTRL_TIMEOUT_EN` defined:
  - A counter in S_WR/S_RD aborts the access after TIMEOUT_CYCLES cycles without `reg_ack_i`.
  - On abort, drop the request, set `err_o`, leave `spi_tx_data_o` = 0xFF for reads, increment the address, and go to S_ACK.
- `SPI_REG_CTRL_TIMEOUT_EN` undefined: no counter; the controller waits for `reg_ack_i` indefinitely, and `err_o` is tied to 0.

## Test plan
- Write frame 0x00, 0x10, 0xA5, 0x3C (zero-wait ack): `reg_wr_o` pulses at addr 0x10 data 0xA5, then at addr 0x11 data 0x3C. Exactly 4 `spi_rdy_ack_o` pulses and 1 `spi_last_byte_ack_o` pulse.
- Read frame 0x80, 0xFE, dummy, dummy, with reg bus returning addr ^ 0x55: reads at 0xFE, 0xFF, 0x00. `spi_tx_data_o` shows 0xAB, then 0xAA, then 0x55.
- `spi_rdy_i` and `spi_last_byte_i` rise in the same cycle during S_DATA write: the write completes first, then the last-byte ack follows, and state returns to S_CMD.
- With `reg_ack_i` delayed 5 cycles: `reg_wr_o` stays high exactly 5 cycles, and `spi_rdy_ack_o` does not pulse before the ack.
- `rst_i` asserted during S_WR: the next cycle shows all outputs 0 and S_CMD. Repeat with `en_i` low; same result.
- `SPI_REG_CTRL_TIMEOUT_EN` defined, reg bus never acks: abort after 16 cycles with `err_o` = 1 and `spi_tx_data_o` = 0xFF. `err_o` clears on the next command byte.

Source files
------------

// File: rtl/spi_slave_reg_ctrl_if.sv
// Word handshake towards spi_slave and request/acknowledge register bus of spi_slave_reg_ctrl.
// The slave modport is the controller's view; master is the surrounding logic.
interface spi_slave_reg_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  spi_rdy_i;
    logic [7:0]            spi_data_i;
    logic                  spi_first_byte_i;
    logic                  spi_last_byte_i;
    logic                  spi_rdy_ack_o;
    logic                  spi_last_byte_ack_o;
    logic [7:0]            spi_tx_data_o;
    logic [ADDR_WIDTH-1:0] reg_addr_o;
    logic [7:0]            reg_data_o;
    logic                  reg_wr_o;
    logic                  reg_rd_o;
    logic [7:0]            reg_data_i;
    logic                  reg_ack_i;
    logic                  err_o;

    modport slave (
        input  spi_rdy_i, spi_data_i, spi_first_byte_i, spi_last_byte_i, reg_data_i, reg_ack_i,
        output spi_rdy_ack_o, spi_last_byte_ack_o, spi_tx_data_o, reg_addr_o, reg_data_o,
               reg_wr_o, reg_rd_o, err_o
    );

    modport master (
        output spi_rdy_i, spi_data_i, spi_first_byte_i, spi_last_byte_i, reg_data_i, reg_ack_i,
        input  spi_rdy_ack_o, spi_last_byte_ack_o, spi_tx_data_o, reg_addr_o, reg_data_o,
               reg_wr_o, reg_rd_o, err_o
    );
endinterface

// File: rtl/spi_slave_reg_ctrl.sv
// SPI frame decoder (command, address, data with auto-increment) driving a register bus.
// Define SPI_REG_CTRL_TIMEOUT_EN to add the register-bus watchdog and sticky err_o.
module spi_slave_reg_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    spi_slave_reg_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StCmd, StAddr, StData, StWr, StRd, StAck, StLast, StHold
    } state_e;

    state_e                state_q, state_d;
    state_e                phase_q, phase_d;
    logic                  rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            tx_q, tx_d;
    logic                  wr_req_q, wr_req_d;
    logic                  rd_req_q, rd_req_d;
    logic                  rdy_ack_q, rdy_ack_d;
    logic                  last_ack_q, last_ack_d;

`ifdef SPI_REG_CTRL_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            timeout;

    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if ((state_q == StWr || state_q == StRd) && !bus.reg_ack_i && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_d       = tx_q;
        wr_req_d   = 1'b0;
        rd_req_d   = 1'b0;
        rdy_ack_d  = 1'b0;
        last_ack_d = 1'b0;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            StCmd, StAddr, StData: begin
                // A received word wins over a pending frame end; the end is seen on return here.
                if (bus.spi_rdy_i) begin
                    if (bus.spi_first_byte_i || state_q == StCmd) begin
                        rd_d      = bus.spi_data_i[7];
                        state_d   = StAck;
                        phase_d   = StAddr;
                        rdy_ack_d = 1'b1;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
                        err_d     = 1'b0;
`endif
                    end else if (state_q == StAddr) begin
                        addr_d = bus.spi_data_i[ADDR_WIDTH-1:0];
                        if (rd_q) begin
                            state_d  = StRd;
                            rd_req_d = 1'b1;
                        end else begin
                            state_d   = StAck;
                            phase_d   = StData;
                            rdy_ack_d = 1'b1;
                        end
                    end else if (rd_q) begin
                        // Dummy byte of a read frame: prefetch the next register.
                        state_d  = StRd;
                        rd_req_d = 1'b1;
                    end else begin
                        wdata_d  = bus.spi_data_i;
                        state_d  = StWr;
                        wr_req_d = 1'b1;
                    end
                end else if (bus.spi_last_byte_i) begin
                    state_d    = StLast;
                    last_ack_d = 1'b1;
                    tx_d       = 8'h00;
                end
            end
            StWr, StRd: begin
                if (bus.reg_ack_i) begin
                    if (state_q == StRd) begin
                        tx_d = bus.reg_data_i;
                    end
                    addr_d    = addr_q + 1'b1;
                    state_d   = StAck;
                    phase_d   = StData;
                    rdy_ack_d = 1'b1;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
                end else if (timeout) begin
                    if (state_q == StRd) begin
                        tx_d = 8'hFF;
                    end
                    err_d     = 1'b1;
                    addr_d    = addr_q + 1'b1;
                    state_d   = StAck;
                    phase_d   = StData;
                    rdy_ack_d = 1'b1;
`endif
                end else begin
                    wr_req_d = (state_q == StWr);
                    rd_req_d = (state_q == StRd);
                end
            end
            StAck: begin
                state_d = StHold;
            end
            StLast: begin
                state_d = StHold;
                phase_d = StCmd;
            end
            StHold: begin
                // Lets spi_slave's registered rdy_o/last_byte_o clear before they are sampled again.
                state_d = phase_q;
            end
            default: begin
                state_d = StCmd;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            state_q    <= StCmd;
            phase_q    <= StCmd;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            tx_q       <= 8'h00;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            rdy_ack_q  <= 1'b0;
            last_ack_q <= 1'b0;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_q       <= tx_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            rdy_ack_q  <= rdy_ack_d;
            last_ack_q <= last_ack_d;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.spi_rdy_ack_o       = rdy_ack_q;
    assign bus.spi_last_byte_ack_o = last_ack_q;
    assign bus.spi_tx_data_o       = tx_q;
    assign bus.reg_addr_o          = addr_q;
    assign bus.reg_data_o          = wdata_q;
    assign bus.reg_wr_o            = wr_req_q;
    assign bus.reg_rd_o            = rd_req_q;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Bench for spi_slave_reg_ctrl: emulates spi_slave and a register bus returning addr ^ 0x55,
// and checks accesses, handshakes and transmit data against a frame-level model.
module tb_spi_slave_reg_ctrl;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } acc_t;

    typedef struct {
        logic [7:0] b [8];
        int         len;
        int         lat;
        int         exp_nacc;
        logic [7:0] exp_addr;
        logic [7:0] exp_val;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    always #5 clk = ~clk;

    spi_slave_reg_ctrl_if #(.ADDR_WIDTH(8)) bus ();

    spi_slave_reg_ctrl #(
        .ADDR_WIDTH    (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .en_i (en),
        .bus  (bus)
    );

    int   checks = 0;
    int   errors = 0;
    acc_t log_q[$];
    acc_t exp_q[$];
    acc_t resp_e;
    int   ack_lat = 1;
    int   hi_cnt = 0;
    int   rdy_ack_cnt = 0, last_ack_cnt = 0, log_at_last_ack = 0;
    int   overlap_cnt = 0, ack_during_req = 0, err_seen = 0;
    int   wr_run = 0, wr_last_run = 0, rd_run = 0, rd_last_run = 0;

    logic [7:0] fb [8];
    int         fl;
    logic [7:0] last_tx;
    int         n_acc;
    vec_t       tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Register-bus responder and output monitor, all on the falling edge.
    always @(negedge clk) begin
        if (bus.reg_wr_o || bus.reg_rd_o) begin
            hi_cnt = hi_cnt + 1;
            bus.reg_data_i = bus.reg_addr_o ^ 8'h55;
            if (hi_cnt == ack_lat) begin
                bus.reg_ack_i = 1'b1;
                resp_e.wr   = bus.reg_wr_o;
                resp_e.addr = bus.reg_addr_o;
                resp_e.data = bus.reg_wr_o ? bus.reg_data_o : 8'h00;
                log_q.push_back(resp_e);
            end else begin
                bus.reg_ack_i = 1'b0;
            end
        end else begin
            hi_cnt = 0;
            bus.reg_ack_i  = 1'b0;
            bus.reg_data_i = 8'hEE;
        end
        if (bus.spi_rdy_ack_o) rdy_ack_cnt++;
        if (bus.spi_last_byte_ack_o) begin
            last_ack_cnt++;
            log_at_last_ack = log_q.size();
        end
        if (bus.reg_wr_o && bus.reg_rd_o) overlap_cnt++;
        if (bus.spi_rdy_ack_o && (bus.reg_wr_o || bus.reg_rd_o)) ack_during_req++;
        if (bus.err_o) err_seen++;
        if (bus.reg_wr_o) wr_run++;
        else begin
            if (wr_run != 0) wr_last_run = wr_run;
            wr_run = 0;
        end
        if (bus.reg_rd_o) rd_run++;
        else begin
            if (rd_run != 0) rd_last_run = rd_run;
            rd_run = 0;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic first, input logic last,
                             input int gap, output logic [7:0] tx, output int lat);
        repeat (gap + 1) @(negedge clk);
        bus.spi_rdy_i        = 1'b1;
        bus.spi_data_i       = d;
        bus.spi_first_byte_i = first;
        if (last) bus.spi_last_byte_i = 1'b1;
        lat = 0;
        tx  = 8'h00;
        for (int i = 1; i <= 300 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.spi_rdy_ack_o) begin
                lat = i;
                tx  = bus.spi_tx_data_o;
            end
        end
        if (lat == 0) check("rdy_ack wait expired", 32'(lat), 32'd1);
        // Hold rdy through the following cycle, like spi_slave's registered clear.
        @(negedge clk);
        bus.spi_rdy_i        = 1'b0;
        bus.spi_first_byte_i = 1'b0;
    endtask

    task automatic end_frame(input logic set_it, output logic [7:0] tx);
        int w;
        if (set_it) begin
            @(negedge clk);
            bus.spi_last_byte_i = 1'b1;
        end
        w  = 0;
        tx = 8'hEE;
        for (int i = 1; i <= 300 && w == 0; i++) begin
            @(negedge clk);
            if (bus.spi_last_byte_ack_o) begin
                w  = i;
                tx = bus.spi_tx_data_o;
            end
        end
        if (w == 0) check("last_byte_ack wait expired", 32'(w), 32'd1);
        @(negedge clk);
        bus.spi_last_byte_i = 1'b0;
    endtask

    // Frame-level model: which register accesses a frame must produce.
    task automatic build_expected();
        acc_t e;
        exp_q.delete();
        if (fl >= 2) begin
            if (fb[0][7]) begin
                for (int k = 1; k < fl; k++) begin
                    e.wr = 1'b0; e.addr = 8'(fb[1] + k - 1); e.data = 8'h00;
                    exp_q.push_back(e);
                end
            end else begin
                for (int k = 2; k < fl; k++) begin
                    e.wr = 1'b1; e.addr = 8'(fb[1] + k - 2); e.data = fb[k];
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic run_frame(input logic first0, input int lat, input int maxgap, input string tag);
        int         s_log, s_ra, s_la, blat;
        logic [7:0] tx;
        ack_lat = lat;
        s_log = log_q.size();
        s_ra  = rdy_ack_cnt;
        s_la  = last_ack_cnt;
        for (int k = 0; k < fl; k++) begin
            send_byte(fb[k], (k == 0) ? first0 : 1'b0, 1'b0, int'($urandom_range(maxgap, 0)),
                      tx, blat);
            if (fb[0][7] && k >= 1) begin
                check({tag, " read tx"}, 32'(tx), 32'(8'(fb[1] + k - 1) ^ 8'h55));
            end
            last_tx = tx;
        end
        end_frame(1'b1, tx);
        check({tag, " tx after frame end"}, 32'(tx), 32'h0);
        build_expected();
        n_acc = log_q.size() - s_log;
        check({tag, " access count"}, 32'(n_acc), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n_acc; i++) begin
            check({tag, " access"}, 32'(log_q[s_log + i]), 32'(exp_q[i]));
        end
        check({tag, " rdy_ack pulses"}, 32'(rdy_ack_cnt - s_ra), 32'(fl));
        check({tag, " last_byte_ack pulses"}, 32'(last_ack_cnt - s_la), 32'd1);
    endtask

    task automatic add_vec(input int i, input logic [63:0] bytes, input int len, input int lat,
                           input int nacc, input logic [7:0] a, input logic [7:0] v);
        for (int k = 0; k < 8; k++) tbl[i].b[k] = bytes[63 - 8 * k -: 8];
        tbl[i].len      = len;
        tbl[i].lat      = lat;
        tbl[i].exp_nacc = nacc;
        tbl[i].exp_addr = a;
        tbl[i].exp_val  = v;
    endtask

    function automatic logic [28:0] outs();
        return {bus.reg_wr_o, bus.reg_rd_o, bus.reg_addr_o, bus.reg_data_o, bus.spi_tx_data_o,
                bus.spi_rdy_ack_o, bus.spi_last_byte_ack_o, bus.err_o};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tx;
        int         blat, s_log, s_la, w;

        // exp_val is write data for write frames, final transmit word for read frames.
        add_vec(0, 64'h0010_A53C_0000_0000, 4, 1, 2, 8'h11, 8'h3C);
        add_vec(1, 64'h80FE_0000_0000_0000, 4, 1, 3, 8'h00, 8'h55);
        add_vec(2, 64'h7F20_1100_0000_0000, 3, 3, 1, 8'h20, 8'h11);
        add_vec(3, 64'hFF05_0000_0000_0000, 2, 2, 1, 8'h05, 8'h50);
        add_vec(4, 64'h00FF_0102_0000_0000, 4, 1, 2, 8'h00, 8'h02);
        add_vec(5, 64'h0040_0000_0000_0000, 2, 1, 0, 8'h00, 8'h00);
        add_vec(6, 64'h807F_AA00_0000_0000, 3, 4, 2, 8'h80, 8'hD5);

        bus.spi_rdy_i        = 1'b0;
        bus.spi_data_i       = 8'h00;
        bus.spi_first_byte_i = 1'b0;
        bus.spi_last_byte_i  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", 32'(outs()), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 8; k++) fb[k] = tbl[i].b[k];
            fl = tbl[i].len;
            run_frame(1'b1, tbl[i].lat, 2, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table count", i), 32'(n_acc), 32'(tbl[i].exp_nacc));
            if (tbl[i].exp_nacc > 0) begin
                check($sformatf("vec%0d last addr", i), 32'(log_q[$].addr), 32'(tbl[i].exp_addr));
                check($sformatf("vec%0d last value", i),
                      fb[0][7] ? 32'(last_tx) : 32'(log_q[$].data), 32'(tbl[i].exp_val));
            end
        end

        // Word and frame end arrive together in the data phase of a write.
        ack_lat = 1;
        s_log = log_q.size();
        s_la  = last_ack_cnt;
        send_byte(8'h00, 1'b1, 1'b0, 0, tx, blat);
        send_byte(8'h30, 1'b0, 1'b0, 0, tx, blat);
        send_byte(8'h77, 1'b0, 1'b1, 0, tx, blat);
        end_frame(1'b0, tx);
        check("rdy+last write count", 32'(log_q.size() - s_log), 32'd1);
        check("rdy+last write", 32'(log_q[$]), 32'({1'b1, 8'h30, 8'h77}));
        check("rdy+last order", 32'(log_at_last_ack - s_log), 32'd1);
        check("rdy+last last ack", 32'(last_ack_cnt - s_la), 32'd1);
        fb[0] = 8'h80; fb[1] = 8'h33; fb[2] = 8'h00; fl = 3;
        run_frame(1'b0, 1, 0, "cmd after rdy+last");

        // A first-byte flag in the data phase restarts decoding as a command.
        send_byte(8'h00, 1'b1, 1'b0, 0, tx, blat);
        send_byte(8'h20, 1'b0, 1'b0, 0, tx, blat);
        fb[0] = 8'h80; fb[1] = 8'h44; fb[2] = 8'h00; fl = 3;
        run_frame(1'b1, 1, 1, "first mid-frame");

        // Register bus acknowledges in the fifth request cycle.
        ack_lat = 5;
        send_byte(8'h00, 1'b1, 1'b0, 0, tx, blat);
        send_byte(8'h50, 1'b0, 1'b0, 0, tx, blat);
        send_byte(8'hC3, 1'b0, 1'b0, 0, tx, blat);
        check("slow ack rdy_ack latency", 32'(blat), 32'd6);
        check("slow ack wr high cycles", 32'(wr_last_run), 32'd5);
        check("slow ack write", 32'(log_q[$]), 32'({1'b1, 8'h50, 8'hC3}));
        end_frame(1'b1, tx);

        // rst_i during a stalled write.
        ack_lat = 1000;
        send_byte(8'h00, 1'b1, 1'b0, 0, tx, blat);
        send_byte(8'h50, 1'b0, 1'b0, 0, tx, blat);
        @(negedge clk);
        bus.spi_rdy_i = 1'b1; bus.spi_data_i = 8'h99;
        w = 0;
        for (int i = 0; i < 20 && w == 0; i++) begin
            @(negedge clk);
            if (bus.reg_wr_o) w = 1;
        end
        check("rst: write request seen", 32'(w), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst during write outputs", 32'(outs()), 32'h0);
        bus.spi_rdy_i = 1'b0;
        rst = 1'b0;
        fb[0] = 8'h00; fb[1] = 8'h60; fb[2] = 8'h99; fl = 3;
        run_frame(1'b0, 1, 0, "cmd after rst");

        // en_i low during a stalled read, with nonzero transmit data pending.
        ack_lat = 1;
        send_byte(8'h80, 1'b1, 1'b0, 0, tx, blat);
        send_byte(8'h70, 1'b0, 1'b0, 0, tx, blat);
        check("en: prefetched tx", 32'(tx), 32'h25);
        ack_lat = 1000;
        @(negedge clk);
        bus.spi_rdy_i = 1'b1; bus.spi_data_i = 8'h00;
        w = 0;
        for (int i = 0; i < 20 && w == 0; i++) begin
            @(negedge clk);
            if (bus.reg_rd_o) w = 1;
        end
        check("en: read request seen", 32'(w), 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("en low during read outputs", 32'(outs()), 32'h0);
        bus.spi_rdy_i = 1'b0;
        en = 1'b1;
        fb[0] = 8'h80; fb[1] = 8'h12; fb[2] = 8'h00; fl = 3;
        run_frame(1'b0, 1, 0, "cmd after en low");

`ifdef SPI_REG_CTRL_TIMEOUT_EN
        ack_lat = 1000;
        send_byte(8'h80, 1'b1, 1'b0, 0, tx, blat);
        send_byte(8'h10, 1'b0, 1'b0, 0, tx, blat);
        check("timeout rdy_ack latency", 32'(blat), 32'd17);
        check("timeout rd high cycles", 32'(rd_last_run), 32'd16);
        check("timeout tx", 32'(tx), 32'hFF);
        check("timeout err", 32'(bus.err_o), 32'd1);
        ack_lat = 1;
        send_byte(8'h00, 1'b0, 1'b0, 0, tx, blat);
        check("timeout next read", 32'(log_q[$]), 32'({1'b0, 8'h11, 8'h00}));
        check("timeout next tx", 32'(tx), 32'h44);
        end_frame(1'b1, tx);
        check("err sticky after frame", 32'(bus.err_o), 32'd1);
        send_byte(8'h00, 1'b1, 1'b0, 0, tx, blat);
        check("err cleared by command", 32'(bus.err_o), 32'd0);
        end_frame(1'b1, tx);
`endif

        for (int r = 0; r < 40; r++) begin
            fl = int'($urandom_range(6, 2));
            for (int k = 0; k < 8; k++) fb[k] = 8'($urandom);
            run_frame(1'b1, int'($urandom_range(4, 1)), 3, $sformatf("rnd%0d", r));
        end

        check("wr and rd never together", 32'(overlap_cnt), 32'd0);
        check("rdy_ack never during request", 32'(ack_during_req), 32'd0);
`ifndef SPI_REG_CTRL_TIMEOUT_EN
        check("err_o stays low", 32'(err_seen), 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
